// File: rtl/btn_pkg.sv
// Shared types and cycle-count profiles for the push-button debouncer.
// The auto-repeat option is enabled with the BTN_DEBOUNCE_AUTOREPEAT_EN macro.
package btn_pkg;

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      RISING  = 2'd1,
      HIGH    = 2'd2,
      FALLING = 2'd3
   } btn_state_t;

   // 100 MHz board profile: 10 ms stability, 0.5 s hold, 0.1 s repeat.
   localparam int BOARD_SYNC_STAGES   = 2;
   localparam int BOARD_STABLE_CYCLES = 1000000;
   localparam int BOARD_HOLD_CYCLES   = 50000000;
   localparam int BOARD_REPEAT_CYCLES = 10000000;

   localparam int SIM_SYNC_STAGES   = 2;
   localparam int SIM_STABLE_CYCLES = 4;
   localparam int SIM_HOLD_CYCLES   = 10;
   localparam int SIM_REPEAT_CYCLES = 5;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_chain.sv
// Multi-flop synchroniser that brings the asynchronous button pin into the clk domain.
// Used by btn_debounce_pulse; the last stage is the only output.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
      end else begin
         r_shift <= {r_shift[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_shift[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchroniser, stability-qualified debounce FSM and edge pulses.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat pulses on btn_rise.
module btn_debounce_pulse
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES   = BOARD_SYNC_STAGES,
   parameter int STABLE_CYCLES = BOARD_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = BOARD_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = BOARD_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam int CW = $clog2(maxOf3(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   logic            w_sync;
   btn_state_t      r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_level;
   logic            r_rise;
   logic            r_fall;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

   logic [CW-1:0]   r_repCnt;
   logic            r_repPhase;
`endif

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (btn_in),
      .o_q (w_sync)
   );

   // r_cnt counts consecutive cycles the synchronised input has disagreed with the level;
   // the compare against STABLE_LAST caps it, so it can never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         r_repCnt   <= '0;
         r_repPhase <= 1'b0;
`endif
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            LOW: begin
               if (w_sync) begin
                  if (STABLE_CYCLES == 1) begin
                     r_state <= HIGH;
                     r_level <= 1'b1;
                     r_rise  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= RISING;
                     r_cnt   <= CNT_ONE;
                  end
               end
            end
            RISING: begin
               if (!w_sync) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == STABLE_LAST) begin
                  r_state <= HIGH;
                  r_level <= 1'b1;
                  r_rise  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!w_sync) begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                  r_repCnt   <= '0;
                  r_repPhase <= 1'b0;
`endif
                  if (STABLE_CYCLES == 1) begin
                     r_state <= LOW;
                     r_level <= 1'b0;
                     r_fall  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= FALLING;
                     r_cnt   <= CNT_ONE;
                  end
               end else begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                  // First repeat waits the hold time, later ones use the shorter repeat period.
                  if ((!r_repPhase && r_repCnt == HOLD_LAST) ||
                      ( r_repPhase && r_repCnt == REPEAT_LAST)) begin
                     r_rise     <= 1'b1;
                     r_repCnt   <= '0;
                     r_repPhase <= 1'b1;
                  end else begin
                     r_repCnt <= r_repCnt + CNT_ONE;
                  end
`endif
               end
            end
            FALLING: begin
               if (w_sync) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == STABLE_LAST) begin
                  r_state <= LOW;
                  r_level <= 1'b0;
                  r_fall  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= LOW;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign btn_level = r_level;
   assign btn_rise  = r_rise;
   assign btn_fall  = r_fall;

endmodule
